// File: rtl/layer_read_sequencer.sv
// ---------------------------------------------------------------------------
// layer_read_sequencer
//
// Issues the per-layer read stream for the pipelined SISO row unit.  For each
// of MAXITER iterations and each of LAYERS layers it produces a burst of
// ADDRDEPTH consecutive reads (rdlayer / rdaddress with rden_LLR, rden_E).
// Consecutive bursts are separated by LAYER_GAP idle cycles so that LLR
// write-back from the previous layer clears before the next layer reads.
// After the final read the row-unit pipeline drains for PIPESTAGES cycles,
// then done pulses for one cycle.
//
// Optional feature (compile-time macro EARLY_TERM_EN):
//   Adds the syndrome_ok input.  On the last GAP cycle that precedes an
//   iteration wrap, syndrome_ok=1 ends the codeword early: the sequencer
//   drains instead of starting the next iteration, and iter_count keeps the
//   completed iteration.  That last gap cycle already has both enables low,
//   so it serves as the first drain cycle.
//   Without the macro the port is absent and all MAXITER iterations run.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   begin a codeword (sampled only in IDLE)
//   syndrome_ok  in   parity satisfied (EARLY_TERM_EN builds only)
//   rdlayer      out  layer index of the current read
//   rdaddress    out  address of the current read within the layer
//   rden_LLR     out  LLR read enable / row-unit valid
//   rden_E       out  E-memory read enable (low during iteration 0)
//   iter_count   out  current iteration, 0-based
//   busy         out  high from first RUN cycle through last DRAIN cycle
//   done         out  one-cycle completion pulse
//
// Parameter constraints: 2**LAYERBITS >= LAYERS, MAXITER >= 1,
// LAYER_GAP >= 1, PIPESTAGES >= 1, ADDRDEPTH <= 2**ADDRWIDTH.
// All outputs are registered and reset to 0.
// ---------------------------------------------------------------------------
module layer_read_sequencer #(
    parameter int LAYERS     = 2,
    parameter int LAYERBITS  = 1,
    parameter int ADDRWIDTH  = 5,
    parameter int ADDRDEPTH  = 20,
    parameter int MAXITER    = 10,
    parameter int ITERBITS   = 5,
    parameter int LAYER_GAP  = 12,
    parameter int PIPESTAGES = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
`ifdef EARLY_TERM_EN
    input  logic                 syndrome_ok,
`endif
    output logic [LAYERBITS-1:0] rdlayer,
    output logic [ADDRWIDTH-1:0] rdaddress,
    output logic                 rden_LLR,
    output logic                 rden_E,
    output logic [ITERBITS-1:0]  iter_count,
    output logic                 busy,
    output logic                 done
);

    // Gap and drain share one counter, sized for the longer of the two.
    localparam int CNTMAX = (LAYER_GAP > PIPESTAGES) ? LAYER_GAP : PIPESTAGES;
    localparam int CNTW   = (CNTMAX > 1) ? $clog2(CNTMAX) : 1;

    localparam logic [ADDRWIDTH-1:0] ADDR_LAST  = ADDRWIDTH'(ADDRDEPTH - 1);
    localparam logic [LAYERBITS-1:0] LAYER_LAST = LAYERBITS'(LAYERS - 1);
    localparam logic [ITERBITS-1:0]  ITER_LAST  = ITERBITS'(MAXITER - 1);
    localparam logic [CNTW-1:0]      GAP_LAST   = CNTW'(LAYER_GAP - 1);
    localparam logic [CNTW-1:0]      PIPE_LAST  = CNTW'(PIPESTAGES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_GAP   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 r_state;
    logic [ADDRWIDTH-1:0]   r_addr;
    logic [LAYERBITS-1:0]   r_layer;
    logic [ITERBITS-1:0]    r_iter;
    logic [CNTW-1:0]        r_cnt;
    logic                   r_rden_llr;
    logic                   r_rden_e;
    logic                   r_busy;
    logic                   r_done;

    state_t                 w_state_nxt;
    logic [ADDRWIDTH-1:0]   w_addr_nxt;
    logic [LAYERBITS-1:0]   w_layer_nxt;
    logic [ITERBITS-1:0]    w_iter_nxt;
    logic [CNTW-1:0]        w_cnt_nxt;
    logic                   w_rden_llr_nxt;
    logic                   w_rden_e_nxt;
    logic                   w_busy_nxt;
    logic                   w_done_nxt;

    logic                   w_layer_wrap;
    logic                   w_early_exit;

    assign w_layer_wrap = (r_layer == LAYER_LAST);

`ifdef EARLY_TERM_EN
    assign w_early_exit = w_layer_wrap & syndrome_ok;
`else
    assign w_early_exit = 1'b0;
`endif

    // Next-state and next-output decode; outputs are computed one step ahead
    // so that every output comes straight from a flop.
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_layer_nxt    = r_layer;
        w_iter_nxt     = r_iter;
        w_cnt_nxt      = r_cnt;
        w_rden_llr_nxt = 1'b0;
        w_rden_e_nxt   = 1'b0;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt    = S_RUN;
                    w_addr_nxt     = '0;
                    w_layer_nxt    = '0;
                    w_iter_nxt     = '0;
                    w_cnt_nxt      = '0;
                    w_rden_llr_nxt = 1'b1;
                    w_rden_e_nxt   = 1'b0;
                    w_busy_nxt     = 1'b1;
                end else begin
                    w_state_nxt    = S_IDLE;
                end
            end

            S_RUN: begin
                w_busy_nxt = 1'b1;
                if (r_addr == ADDR_LAST) begin
                    // Burst complete: address and layer hold through the gap.
                    w_cnt_nxt = '0;
                    if (w_layer_wrap && (r_iter == ITER_LAST)) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_state_nxt = S_GAP;
                    end
                end else begin
                    w_addr_nxt     = r_addr + ADDRWIDTH'(1);
                    w_rden_llr_nxt = 1'b1;
                    w_rden_e_nxt   = (r_iter != '0);
                end
            end

            S_GAP: begin
                w_busy_nxt = 1'b1;
                if (r_cnt == GAP_LAST) begin
                    if (w_early_exit) begin
                        // This gap cycle counts as the first drain cycle.
                        if (PIPESTAGES > 1) begin
                            w_state_nxt = S_DRAIN;
                            w_cnt_nxt   = CNTW'(1);
                        end else begin
                            w_state_nxt = S_DONE;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_state_nxt    = S_RUN;
                        w_addr_nxt     = '0;
                        w_rden_llr_nxt = 1'b1;
                        if (w_layer_wrap) begin
                            w_layer_nxt  = '0;
                            w_iter_nxt   = r_iter + ITERBITS'(1);
                            w_rden_e_nxt = 1'b1;
                        end else begin
                            w_layer_nxt  = r_layer + LAYERBITS'(1);
                            w_rden_e_nxt = (r_iter != '0);
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNTW'(1);
                end
            end

            S_DRAIN: begin
                if (r_cnt == PIPE_LAST) begin
                    w_state_nxt = S_DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt  = r_cnt + CNTW'(1);
                    w_busy_nxt = 1'b1;
                end
            end

            S_DONE: begin
                // iter_count keeps the final iteration until the next start.
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset aborts any run at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_layer    <= '0;
            r_iter     <= '0;
            r_cnt      <= '0;
            r_rden_llr <= 1'b0;
            r_rden_e   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_layer    <= w_layer_nxt;
            r_iter     <= w_iter_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rden_llr <= w_rden_llr_nxt;
            r_rden_e   <= w_rden_e_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign rdlayer    = r_layer;
    assign rdaddress  = r_addr;
    assign rden_LLR   = r_rden_llr;
    assign rden_E     = r_rden_e;
    assign iter_count = r_iter;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_layer_read_sequencer.sv
// ---------------------------------------------------------------------------
// tb_layer_read_sequencer
//
// Directed bench for layer_read_sequencer with ADDRDEPTH=4, LAYERS=2,
// LAYER_GAP=2, PIPESTAGES=3.  dut0 runs MAXITER=2, dut1 runs MAXITER=1.
// Cycle k is the clock period that follows rising edge k-1; start is
// sampled at edge 0, outputs are sampled 1 time unit after each edge.
// Expected observation vector: {rden_LLR, rden_E, busy, done, rdlayer,
// rdaddress, iter_count} (15 bits).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_layer_read_sequencer;

    logic       clk;
    logic       rst;
    logic       start0;
    logic       start1;
    logic       syn0;
    logic       syn1;

    logic       l0;
    logic [4:0] a0;
    logic       llr0, e0, busy0, done0;
    logic [4:0] it0;
    logic       l1;
    logic [4:0] a1;
    logic       llr1, e1, busy1, done1;
    logic [4:0] it1;

    int n_checks;
    int n_fail;

    localparam logic [14:0] MASK_ALL  = 15'h7FFF;
    localparam logic [14:0] MASK_NOLA = 15'h781F;

    layer_read_sequencer #(
        .LAYERS(2), .LAYERBITS(1), .ADDRWIDTH(5), .ADDRDEPTH(4),
        .MAXITER(2), .ITERBITS(5), .LAYER_GAP(2), .PIPESTAGES(3)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start0),
`ifdef EARLY_TERM_EN
        .syndrome_ok(syn0),
`endif
        .rdlayer(l0), .rdaddress(a0), .rden_LLR(llr0), .rden_E(e0),
        .iter_count(it0), .busy(busy0), .done(done0)
    );

    layer_read_sequencer #(
        .LAYERS(2), .LAYERBITS(1), .ADDRWIDTH(5), .ADDRDEPTH(4),
        .MAXITER(1), .ITERBITS(5), .LAYER_GAP(2), .PIPESTAGES(3)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start1),
`ifdef EARLY_TERM_EN
        .syndrome_ok(syn1),
`endif
        .rdlayer(l1), .rdaddress(a1), .rden_LLR(llr1), .rden_E(e1),
        .iter_count(it1), .busy(busy1), .done(done1)
    );

    wire [14:0] act0 = {llr0, e0, busy0, done0, l0, a0, it0};
    wire [14:0] act1 = {llr1, e1, busy1, done1, l1, a1, it1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-derived timeline: burst b covers cycles 6b+1..6b+4, gap 6b+5..6b+6,
    // drain 3 cycles after the last read, done at 6*nb+2 (nb = 2*maxit bursts).
    function automatic logic [14:0] exp_vec(input int c, input int maxit);
        int nb, b, o;
        logic llr, e, bsy, dn, lay;
        logic [4:0] adr, itr;
        nb = 2 * maxit;
        llr = 1'b0; e = 1'b0; bsy = 1'b0; dn = 1'b0; lay = 1'b0;
        adr = 5'd0; itr = 5'd0;
        if (c < 1) begin
            itr = 5'd0;
        end else if (c <= 6 * nb - 2) begin
            b   = (c - 1) / 6;
            o   = (c - 1) % 6;
            lay = b[0];
            itr = 5'(b / 2);
            bsy = 1'b1;
            if (o < 4) begin
                llr = 1'b1;
                e   = (itr != 5'd0);
                adr = 5'(o);
            end else begin
                adr = 5'd3;
            end
        end else if (c <= 6 * nb + 1) begin
            bsy = 1'b1;
            itr = 5'(maxit - 1);
        end else if (c == 6 * nb + 2) begin
            dn  = 1'b1;
            itr = 5'(maxit - 1);
        end else begin
            itr = 5'(maxit - 1);
        end
        return {llr, e, bsy, dn, lay, adr, itr};
    endfunction

    function automatic logic [14:0] mask_for(input int c, input int maxit);
        return (c <= 12 * maxit - 2) ? MASK_ALL : MASK_NOLA;
    endfunction

    task automatic test_reset;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; syn0 = 1'b0; syn1 = 1'b0;
        #2;
        n_checks++;
        if (act0 !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_dut0 got %h expected %h", act0, 15'd0);
        end
        n_checks++;
        if (act1 !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_dut1 got %h expected %h", act1, 15'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (act0 !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_idle got %h expected %h", act0, 15'd0);
        end
    endtask

    task automatic test_nominal;
        logic [14:0] ex, m;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        for (int c = 1; c <= 28; c++) begin
            ex = exp_vec(c, 2);
            m  = mask_for(c, 2);
            n_checks++;
            if ((act0 & m) !== (ex & m)) begin
                n_fail++;
                $display("FAIL nominal_cycle%0d got %h expected %h", c, act0 & m, ex & m);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_gap_hold;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 5 || c == 6) begin
                n_checks++;
                if ({llr0, e0, l0, a0} !== {1'b0, 1'b0, 1'b0, 5'd3}) begin
                    n_fail++;
                    $display("FAIL gap_hold_cycle%0d got llr=%b e=%b layer=%0d addr=%0d expected 0 0 0 3",
                             c, llr0, e0, l0, a0);
                end
            end
            if (c == 7) begin
                n_checks++;
                if ({llr0, l0, a0} !== {1'b1, 1'b1, 5'd0}) begin
                    n_fail++;
                    $display("FAIL gap_exit_cycle7 got llr=%b layer=%0d addr=%0d expected 1 1 0",
                             llr0, l0, a0);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_busy_start;
        logic [14:0] ex;
        start0 = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 28; c++) begin
            if (c <= 26) begin
                ex = exp_vec(c, 2);
                n_checks++;
                if ((act0 & MASK_NOLA) !== (ex & MASK_NOLA)) begin
                    n_fail++;
                    $display("FAIL busy_start_cycle%0d got %h expected %h",
                             c, act0 & MASK_NOLA, ex & MASK_NOLA);
                end
            end
            if (c == 28) begin
                n_checks++;
                if ({llr0, e0, busy0, l0, a0, it0} !== {1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0}) begin
                    n_fail++;
                    $display("FAIL restart_cycle28 got llr=%b e=%b busy=%b layer=%0d addr=%0d iter=%0d expected 1 0 1 0 0 0",
                             llr0, e0, busy0, l0, a0, it0);
                end
            end
            @(posedge clk); #1;
        end
        start0 = 1'b0;
        repeat (30) @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset;
        logic [14:0] ex;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
        end
        // now 1 time unit into cycle 8 (layer 1 burst)
        n_checks++;
        if (llr0 !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_read got %b expected %b", llr0, 1'b1);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (act0 !== 15'd0) begin
            n_fail++;
            $display("FAIL async_reset got %h expected %h", act0, 15'd0);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({busy0, done0} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_hold%0d got busy=%b done=%b expected 0 0", k, busy0, done0);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            ex = exp_vec(c, 2);
            n_checks++;
            if (act0 !== ex) begin
                n_fail++;
                $display("FAIL post_reset_cycle%0d got %h expected %h", c, act0, ex);
            end
            @(posedge clk); #1;
        end
        repeat (22) @(posedge clk);
        #1;
    endtask

    task automatic test_maxiter1;
        logic [14:0] ex, m;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            ex = exp_vec(c, 1);
            m  = mask_for(c, 1);
            n_checks++;
            if ((act1 & m) !== (ex & m)) begin
                n_fail++;
                $display("FAIL maxiter1_cycle%0d got %h expected %h", c, act1 & m, ex & m);
            end
            n_checks++;
            if (e1 !== 1'b0) begin
                n_fail++;
                $display("FAIL maxiter1_rdenE_cycle%0d got %b expected %b", c, e1, 1'b0);
            end
            @(posedge clk); #1;
        end
    endtask

`ifdef EARLY_TERM_EN
    task automatic test_early_term;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            syn0 = (c == 12);
            if (c == 13 || c == 14) begin
                n_checks++;
                if ({llr0, busy0, done0} !== 3'b010) begin
                    n_fail++;
                    $display("FAIL early_drain_cycle%0d got llr=%b busy=%b done=%b expected 0 1 0",
                             c, llr0, busy0, done0);
                end
            end
            if (c == 15) begin
                n_checks++;
                if ({done0, busy0, it0} !== {1'b1, 1'b0, 5'd0}) begin
                    n_fail++;
                    $display("FAIL early_done_cycle15 got done=%b busy=%b iter=%0d expected 1 0 0",
                             done0, busy0, it0);
                end
            end
            if (c == 16) begin
                n_checks++;
                if (done0 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL early_done_pulse got %b expected %b", done0, 1'b0);
                end
            end
            @(posedge clk); #1;
        end
        syn0 = 1'b0;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_nominal();
        test_gap_hold();
        test_busy_start();
        test_async_reset();
        test_maxiter1();
`ifdef EARLY_TERM_EN
        test_early_term();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
